// File: rtl/tictactoe.sv
// Two-player tic-tac-toe engine: board, turn tracking, win/cat/error detection, blinking win display.
// Optional blinking cursor on the selected empty square: define TICTACTOE_CURSOR_FLASH_EN.
module tictactoe (
  input  logic       clk,
  input  logic       reset,
  input  logic       flash_clk,
  input  logic [8:0] sel_pos,
  input  logic       buttonX,
  input  logic       buttonO,
  output logic       turnX,
  output logic       turnO,
  output logic [8:0] occ_pos,
  output logic [8:0] occ_square,
  output logic [8:0] occ_player,
  output logic [7:0] game_st
);

  typedef enum logic [2:0] {
    ST_PLAY,
    ST_XWIN,
    ST_OWIN,
    ST_CAT,
    ST_ERR
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] occ_square_q, occ_square_d;
  logic [8:0] occ_player_q, occ_player_d;
  logic [8:0] win_mask_q, win_mask_d;
  logic       turn_x_q, turn_x_d;

  logic [8:0] new_square, new_player, mover_tiles, new_win;
  logic [8:0] line_win [8];
  logic       multi_sel, any_btn, legal;

  // Squares covered by each of the 8 winning lines: rows, columns, diagonals.
  function automatic logic [8:0] line_mask(input int idx);
    case (idx)
      0:       line_mask = 9'b000_000_111;
      1:       line_mask = 9'b000_111_000;
      2:       line_mask = 9'b111_000_000;
      3:       line_mask = 9'b001_001_001;
      4:       line_mask = 9'b010_010_010;
      5:       line_mask = 9'b100_100_100;
      6:       line_mask = 9'b100_010_001;
      default: line_mask = 9'b001_010_100;
    endcase
  endfunction

  assign multi_sel   = |(sel_pos & (sel_pos - 9'd1));
  assign any_btn     = buttonX | buttonO;
  assign new_square  = occ_square_q | sel_pos;
  assign new_player  = occ_player_q | (buttonX ? sel_pos : 9'd0);
  assign mover_tiles = buttonX ? new_player : (new_square & ~new_player);

  assign legal = (buttonX ^ buttonO) && !multi_sel && (|sel_pos) &&
                 (buttonX == turn_x_q) && !(|(sel_pos & occ_square_q));

  // Each line contributes its mask when the mover owns all three of its squares.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_line
      assign line_win[gi] = ((mover_tiles & line_mask(gi)) == line_mask(gi)) ? line_mask(gi) : 9'd0;
    end
  endgenerate

  always_comb begin
    new_win = 9'd0;
    for (int i = 0; i < 8; i++) begin
      new_win = new_win | line_win[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    occ_square_d = occ_square_q;
    occ_player_d = occ_player_q;
    win_mask_d   = win_mask_q;
    turn_x_d     = turn_x_q;
    if (state_q == ST_PLAY) begin
      if ((buttonX && buttonO) || (any_btn && multi_sel)) begin
        state_d = ST_ERR;
      end else if (legal) begin
        occ_square_d = new_square;
        occ_player_d = new_player;
        turn_x_d     = ~turn_x_q;
        if (|new_win) begin
          win_mask_d = new_win;
          state_d    = buttonX ? ST_XWIN : ST_OWIN;
        end else if (&new_square) begin
          state_d = ST_CAT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_PLAY;
      occ_square_q <= 9'd0;
      occ_player_q <= 9'd0;
      win_mask_q   <= 9'd0;
      turn_x_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      occ_square_q <= occ_square_d;
      occ_player_q <= occ_player_d;
      win_mask_q   <= win_mask_d;
      turn_x_q     <= turn_x_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_XWIN: game_st = 8'h58;
      ST_OWIN: game_st = 8'h4F;
      ST_CAT:  game_st = 8'h43;
      ST_ERR:  game_st = 8'h45;
      default: game_st = 8'h6E;
    endcase
  end

  assign turnX      = (state_q == ST_PLAY) &&  turn_x_q;
  assign turnO      = (state_q == ST_PLAY) && !turn_x_q;
  assign occ_square = occ_square_q;
  assign occ_player = occ_player_q;

`ifdef TICTACTOE_CURSOR_FLASH_EN
  assign occ_pos = (occ_square_q & ~win_mask_q) | (win_mask_q & {9{flash_clk}}) |
                   (((state_q == ST_PLAY) ? (sel_pos & ~occ_square_q) : 9'd0) & {9{flash_clk}});
`else
  assign occ_pos = (occ_square_q & ~win_mask_q) | (win_mask_q & {9{flash_clk}});
`endif

endmodule

// File: tb/tb_tictactoe.sv
// Self-checking bench for tictactoe: directed game scenarios plus random play against a board-level model.
module tb_tictactoe;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flash_clk = 1'b0;
  logic [8:0] sel_pos = 9'd0;
  logic       buttonX = 1'b0;
  logic       buttonO = 1'b0;
  logic       turnX, turnO;
  logic [8:0] occ_pos, occ_square, occ_player;
  logic [7:0] game_st;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: board as characters, status as the ASCII state letter.
  byte        board [9];
  byte        status;
  bit         x_turn;
  logic [8:0] m_win;
  int         lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                               '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  tictactoe dut (
    .clk(clk), .reset(reset), .flash_clk(flash_clk), .sel_pos(sel_pos),
    .buttonX(buttonX), .buttonO(buttonO), .turnX(turnX), .turnO(turnO),
    .occ_pos(occ_pos), .occ_square(occ_square), .occ_player(occ_player), .game_st(game_st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) board[i] = 8'd0;
    status = "n";
    x_turn = 1'b1;
    m_win  = 9'd0;
  endtask

  task automatic model_apply(input bit bx, input bit bo, input logic [8:0] sel);
    int  cnt, idx;
    byte mover;
    bit  full;
    if (status != "n") return;
    cnt = $countones(sel);
    if ((bx && bo) || ((bx || bo) && cnt > 1)) begin
      status = "E";
      return;
    end
    if (!(bx || bo) || cnt == 0) return;
    idx = 0;
    for (int i = 0; i < 9; i++) if (sel[i]) idx = i;
    mover = bx ? "X" : "O";
    if ((bx != x_turn) || board[idx] != 8'd0) return;
    board[idx] = mover;
    x_turn = !x_turn;
    for (int l = 0; l < 8; l++) begin
      if (board[lines[l][0]] == mover && board[lines[l][1]] == mover && board[lines[l][2]] == mover) begin
        m_win[lines[l][0]] = 1'b1;
        m_win[lines[l][1]] = 1'b1;
        m_win[lines[l][2]] = 1'b1;
        status = mover;
      end
    end
    full = 1'b1;
    for (int i = 0; i < 9; i++) if (board[i] == 8'd0) full = 1'b0;
    if (status == "n" && full) status = "C";
  endtask

  task automatic check_all(input string ctx);
    logic [8:0] e_sq, e_pl, e_pos;
    for (int i = 0; i < 9; i++) begin
      e_sq[i] = (board[i] != 8'd0);
      e_pl[i] = (board[i] == "X");
    end
    e_pos = (e_sq & ~m_win) | (m_win & {9{flash_clk}});
`ifdef TICTACTOE_CURSOR_FLASH_EN
    if (status == "n") e_pos = e_pos | (sel_pos & ~e_sq & {9{flash_clk}});
`endif
    chk({ctx, ".occ_square"}, occ_square, e_sq);
    chk({ctx, ".occ_player"}, occ_player, e_pl);
    chk({ctx, ".turnX"}, {8'd0, turnX}, {8'd0, (status == "n") && x_turn});
    chk({ctx, ".turnO"}, {8'd0, turnO}, {8'd0, (status == "n") && !x_turn});
    chk({ctx, ".game_st"}, {1'b0, game_st}, {1'b0, status});
    chk({ctx, ".occ_pos"}, occ_pos, e_pos);
  endtask

  task automatic step(input string ctx, input bit bx, input bit bo, input logic [8:0] sel, input bit fl);
    @(negedge clk);
    buttonX = bx; buttonO = bo; sel_pos = sel; flash_clk = fl;
    @(posedge clk);
    model_apply(bx, bo, sel);
    #1;
    check_all(ctx);
    $display("step %s bx=%0b bo=%0b sel=%b -> st=%s sq=%b pl=%b", ctx, bx, bo, sel, game_st, occ_square, occ_player);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1; buttonX = 1'b0; buttonO = 1'b0; sel_pos = 9'd0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check_all("reset");
  endtask

  function automatic logic [8:0] sq(input int k);
    logic [8:0] v;
    v = 9'd1 << k;
    return v;
  endfunction

  initial begin
    logic [8:0] rsel;
    bit rbx, rbo;
    int r;
    model_reset();

    // Reset and first moves, ignored actions
    do_reset(10);
    chk("reset.game_st_const", {1'b0, game_st}, 9'h06E);
    step("x0", 1, 0, sq(0), 0);
    chk("x0.player_const", occ_player, 9'b000000001);
    step("x_wrong_turn", 1, 0, sq(1), 0);
    step("o_occupied", 0, 1, sq(0), 0);
    step("o_zero_sel", 0, 1, 9'd0, 0);
    chk("ignored.turnO_const", {8'd0, turnO}, 9'd1);

    // X wins row 0
    step("o3", 0, 1, sq(3), 1);
    step("x1", 1, 0, sq(1), 1);
    step("o4", 0, 1, sq(4), 1);
    step("x2_win", 1, 0, sq(2), 1);
    chk("xwin.square_const", occ_square, 9'b000011111);
    chk("xwin.pos_flash1", occ_pos, 9'b000011111);
    flash_clk = 1'b0; #1;
    chk("xwin.pos_flash0", occ_pos, 9'b000011000);
    step("xwin_hold", 0, 1, sq(8), 0);

    // Cat's game
    do_reset(2);
    step("c_x0", 1, 0, sq(0), 0); step("c_o1", 0, 1, sq(1), 1);
    step("c_x2", 1, 0, sq(2), 0); step("c_o4", 0, 1, sq(4), 1);
    step("c_x3", 1, 0, sq(3), 0); step("c_o5", 0, 1, sq(5), 1);
    step("c_x7", 1, 0, sq(7), 0); step("c_o6", 0, 1, sq(6), 1);
    step("c_x8", 1, 0, sq(8), 1);
    chk("cat.game_st_const", {1'b0, game_st}, 9'h043);
    chk("cat.player_const", occ_player, 9'b110001101);

    // Error paths, then asynchronous reset between clock edges
    do_reset(2);
    step("e_x0", 1, 0, sq(0), 0);
    step("e_both", 1, 1, sq(5), 0);
    chk("err.game_st_const", {1'b0, game_st}, 9'h045);
    step("e_frozen", 0, 1, sq(5), 0);
    do_reset(2);
    step("e_multi", 1, 0, 9'b000000110, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk); reset = 1'b0;

    // Random games
    for (int g = 0; g < 40; g++) begin
      do_reset(2);
      for (int s = 0; s < 25; s++) begin
        r = $urandom_range(0, 99);
        rbx = 0; rbo = 0;
        rsel = sq($urandom_range(0, 8));
        if (r < 2) begin
          rbx = 1; rbo = 1;
        end else if (r < 4) begin
          do rsel = 9'($urandom); while ($countones(rsel) < 2);
          if ($urandom_range(0, 1) == 1) rbx = 1; else rbo = 1;
        end else if (r < 10) begin
          rsel = 9'd0;
          if ($urandom_range(0, 1) == 1) rbx = 1; else rbo = 1;
        end else if (r < 15) begin
          rbx = 0; rbo = 0;
        end else if (r < 80) begin
          if (x_turn) rbx = 1; else rbo = 1;
        end else begin
          if (x_turn) rbo = 1; else rbx = 1;
        end
        step("rand", rbx, rbo, rsel, 1'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tictactoe.md
Name: tictactoe

Overview:
- Two-player tic-tac-toe game engine; sits between the board/button front-end and the display/LED logic.
- Holds a 3x3 board and tracks whose turn it is. Accepts moves from a one-hot position select plus per-player buttons.
- Detects win, cat's game and error conditions. Reports the game state as an ASCII code.
- Drives a display vector that blinks the winning line using a slow flash clock.

Parameters:
- None. Board size is fixed at 9 squares; ASCII codes are fixed.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears the game.
- flash_clk  input  1  slow blink clock; used only as a data level for occ_pos, never as a clock.
- sel_pos  input  9  one-hot selected square; bit k = square k (row-major, bit 0 = first square).
- buttonX  input  1  X player places on sel_pos, sampled at clk rise.
- buttonO  input  1  O player places on sel_pos, sampled at clk rise.
- turnX  output  1  high when X may move.
- turnO  output  1  high when O may move.
- occ_pos  output  9  display vector (see Behaviour).
- occ_square  output  9  bit k = 1 if square k is occupied.
- occ_player  output  9  bit k = 1 if square k is owned by X; 0 if owned by O or empty.
- game_st  output  8  ASCII state: 'n' 0x6E in progress, 'X' 0x58 X won, 'O' 0x4F O won, 'C' 0x43 cat's game, 'E' 0x45 error.

Behaviour:
- Reset (asynchronous, while high): occ_square=0, occ_player=0, turnX=1, turnO=0, game_st='n', win mask=0, occ_pos=0. X always moves first.
- All outputs except occ_pos are registered. A move presented at rising edge N is reflected in every output immediately after edge N: one-cycle latency, no busy cycles.
- Legal move (game_st='n', exactly one button high, that player's turn, sel_pos exactly one bit set, square empty):
  - set occ_square bit;
  - set occ_player bit =1 for X, leave 0 for O;
  - toggle turnX/turnO.
- Ignored actions, no state change, game_st stays 'n':
  - button of the player who is not on turn;
  - selected square already occupied;
  - sel_pos all zero.
  - Consequence: a button held for several cycles places only one tile.
- Error, terminal:
  - trigger: buttonX and buttonO both high in the same cycle, or a button high with more than one sel_pos bit set;
  - game_st='E', turnX=turnO=0, board frozen.
- Win check after each legal move, over 8 lines: 3 rows, 3 columns, 2 diagonals.
  - A line fully owned by the mover sets game_st='X' or 'O' and latches that line into the internal 9-bit win mask.
  - If several lines complete at once, OR them into the mask.
  - A win on the ninth move takes priority over cat's game.
- Cat's game: all 9 squares occupied with no win → game_st='C'.
- Any terminal state ('X','O','C','E'): turnX=turnO=0; buttons ignored until reset.
- occ_pos (combinational): occ_square & ~win_mask, OR (win_mask & {9{flash_clk}}). Winning squares blink; other occupied squares are steady.
- Reset asserted mid-game returns to the reset state at once, regardless of clk.

Optional Feature:
- Macro: TICTACTOE_CURSOR_FLASH_EN.
- Defined, while game_st='n': the selected empty square (sel_pos & ~occ_square) is ORed into occ_pos gated by flash_clk, giving a blinking cursor.
- Not defined: occ_pos follows only the rule in Behaviour; the cursor is not shown.

Test Plan:
- Reset held 10 cycles then released -> turnX=1, turnO=0, occ_square=0, occ_player=0, game_st=0x6E.
- sel_pos=000000001, buttonX 1 cycle -> occ_square=000000001, occ_player=000000001, turnX=0, turnO=1.
- Then buttonX on sel_pos=000000010 (wrong player), and buttonO on sel_pos=000000001 (occupied) -> board and turn unchanged, game_st='n'.
- X on 0,1,2 with O on 3,4 -> after X on square 2: game_st='X', turnX=turnO=0, occ_square=000011111, occ_player=000000111, occ_pos bits 2:0 follow flash_clk.
- Full board with no line: X on 0,2,3,7,8 and O on 1,4,5,6 -> game_st='C', occ_square=111111111, occ_player=110001101.
- buttonX and buttonO together -> game_st='E', turns low. Asynchronous reset mid-cycle -> immediate return to reset values.
